// File: rtl/cdr_loop_filter.sv
// cdr_loop_filter
//   Digital PI loop filter and phase accumulator of the CDR. The phase-detector
//   error has the PD offset removed (external or zero), is scaled by the
//   proportional and integral power-of-two gains, and is integrated into a
//   cyclic phase accumulator whose top Npi bits drive the phase interpolator.
//   JTAG overrides can force the PI code and supply the PD offset.
//
// Ports
//   clk                sole clock
//   rst                synchronous reset, active-high
//   pd_valid           pd_in valid this cycle
//   pd_in              signed phase error (Nadc bits)
//   sel_ext_pd_offset  use pd_offset_ext as PD offset (else 0); quasi-static
//   pd_offset_ext      signed PD offset (Nadc bits)
//   sel_ext_pi         force the PI code from pi_ctl_ext; quasi-static
//   pi_ctl_ext         forced PI code (Npi bits)
//   kp_shift           proportional gain 2^kp (0..8; 9..14 -> 8; 15 -> gain 0)
//   ki_shift           integral gain 2^ki (same coding)
//   pi_ctl             PI control code to interpolator
//   pi_ctl_upd         one-cycle pulse when the loop updated pi_ctl
module cdr_loop_filter #(
  parameter int Npi   = 9,
  parameter int Nadc  = 8,
  parameter int Nfrac = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pd_valid,
  input  logic [Nadc-1:0] pd_in,
  input  logic            sel_ext_pd_offset,
  input  logic [Nadc-1:0] pd_offset_ext,
  input  logic            sel_ext_pi,
  input  logic [Npi-1:0]  pi_ctl_ext,
  input  logic [3:0]      kp_shift,
  input  logic [3:0]      ki_shift,
  output logic [Npi-1:0]  pi_ctl,
  output logic            pi_ctl_upd
);

  localparam int W = Npi + Nfrac;

  localparam logic [0:0] ST_TRACK = 1'b0;
  localparam logic [0:0] ST_EXT   = 1'b1;

  logic [1:0]            sync_pi_reg;
  logic [1:0]            sync_off_reg;
  logic [0:0]            state_reg;
  logic signed [Nadc:0]  err_reg;
  logic                  err_v_reg;
  logic signed [W-1:0]   integ_reg;
  logic [W-1:0]          acc_reg;
  logic                  upd_reg;

  logic [Nadc-1:0]       off_sel;
  logic signed [Nadc:0]  err_next;
  logic signed [W-1:0]   err_ext;
  logic [3:0]            kp_amt;
  logic [3:0]            ki_amt;
  logic signed [W-1:0]   p_val;
  logic signed [W-1:0]   i_val;
  logic signed [W:0]     integ_sum;
  logic signed [W-1:0]   integ_next;
  logic [W-1:0]          acc_next;

  always_comb begin
    off_sel  = sync_off_reg[1] ? pd_offset_ext : '0;
    // One extra bit keeps pd_in - offset exact (no saturation needed).
    err_next = {pd_in[Nadc-1], pd_in} - {off_sel[Nadc-1], off_sel};

    err_ext  = {{(W-Nadc-1){err_reg[Nadc]}}, err_reg};
    kp_amt   = (kp_shift > 4'd8) ? 4'd8 : kp_shift;
    ki_amt   = (ki_shift > 4'd8) ? 4'd8 : ki_shift;
    p_val    = (kp_shift == 4'hF) ? '0 : (err_ext <<< kp_amt);
    i_val    = (ki_shift == 4'hF) ? '0 : (err_ext <<< ki_amt);

    // Integrator saturates: a sign mismatch between the two top bits of the
    // one-bit-wider sum means the signed W-bit range was left.
    integ_sum = {integ_reg[W-1], integ_reg} + {i_val[W-1], i_val};
    if (integ_sum[W] != integ_sum[W-1]) begin
      integ_next = integ_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      integ_next = integ_sum[W-1:0];
    end

    // The accumulator is a phase: wrap-around modulo 2^W is intended.
    acc_next = acc_reg + p_val + integ_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_pi_reg  <= '0;
      sync_off_reg <= '0;
      state_reg    <= ST_TRACK;
      err_reg      <= '0;
      err_v_reg    <= 1'b0;
      integ_reg    <= '0;
      acc_reg      <= '0;
      upd_reg      <= 1'b0;
    end else begin
      sync_pi_reg  <= {sync_pi_reg[0], sel_ext_pi};
      sync_off_reg <= {sync_off_reg[0], sel_ext_pd_offset};
      upd_reg      <= 1'b0;

      case (state_reg)
        ST_TRACK: begin
          if (sync_pi_reg[1]) begin
            // Mode change wins over a pending error: flush the pipeline.
            state_reg <= ST_EXT;
            acc_reg   <= {pi_ctl_ext, {Nfrac{1'b0}}};
            err_reg   <= '0;
            err_v_reg <= 1'b0;
          end else begin
            err_v_reg <= pd_valid;
            if (pd_valid) begin
              err_reg <= err_next;
            end
            if (err_v_reg) begin
              integ_reg <= integ_next;
              acc_reg   <= acc_next;
              upd_reg   <= 1'b1;
            end
          end
        end
        default: begin
          // Forced code; integrator is held so release is bumpless.
          acc_reg   <= {pi_ctl_ext, {Nfrac{1'b0}}};
          err_reg   <= '0;
          err_v_reg <= 1'b0;
          if (!sync_pi_reg[1]) begin
            state_reg <= ST_TRACK;
          end
        end
      endcase
    end
  end

  assign pi_ctl     = acc_reg[W-1 -: Npi];
  assign pi_ctl_upd = upd_reg;

endmodule
